// File: rtl/mbldcm_pkg.sv
// Shared definitions for the BLDC motor-control blocks: default field widths,
// PWM register reset values and the PWM generator state encoding.
package mbldcm_pkg;

  localparam int unsigned cPrscWidth = 6;
  localparam int unsigned cCntWidth  = 16;

  localparam logic [cPrscWidth-1:0] cPrscRst   = '0;
  localparam logic [cCntWidth-1:0]  cMaxCntRst = 16'hFFFF;
  localparam logic [cCntWidth:0]    cCmpRst    = '0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pwmState_t;

endpackage

// File: rtl/mbldcm_pwm_gen_if.sv
// Register-side configuration and waveform outputs of the PWM carrier generator.
// The master is the register block / commutation stage, the slave is the generator.
interface mbldcm_pwm_gen_if
  import mbldcm_pkg::*;
#(
  parameter int pPrscWidth = cPrscWidth,
  parameter int pCntWidth  = cCntWidth
);

  logic                  iEnable;
  logic [pPrscWidth-1:0] iPwmPrsc;
  logic [pCntWidth-1:0]  iPwmMaxCnt;
  logic [pCntWidth:0]    iPwmCmp;
  logic                  oPwm;
  logic                  oPeriodEnd;
  logic                  oRunning;

  modport master (
    output iEnable, iPwmPrsc, iPwmMaxCnt, iPwmCmp,
    input  oPwm, oPeriodEnd, oRunning
  );

  modport slave (
    input  iEnable, iPwmPrsc, iPwmMaxCnt, iPwmCmp,
    output oPwm, oPeriodEnd, oRunning
  );

endinterface

// File: rtl/mbldcm_prescaler.sv
// Clock prescaler for the PWM period counter: oTick is high one clock in every
// (iPrsc+1) while not cleared; iClear holds the count at zero.
module mbldcm_prescaler
  import mbldcm_pkg::*;
#(
  parameter int pPrscWidth = cPrscWidth
) (
  input  logic                  iClock,
  input  logic                  iReset_n,
  input  logic                  iClear,
  input  logic [pPrscWidth-1:0] iPrsc,
  output logic                  oTick
);

  logic [pPrscWidth-1:0] rPrscCnt;

  assign oTick = !iClear && (rPrscCnt == iPrsc);

  always_ff @(posedge iClock) begin
    if (!iReset_n || iClear) begin
      rPrscCnt <= '0;
    end else if (oTick) begin
      rPrscCnt <= '0;
    end else begin
      rPrscCnt <= rPrscCnt + 1'b1;
    end
  end

endmodule

// File: rtl/mbldcm_pwm_gen.sv
// PWM carrier generator for the BLDC gate commutation stage. Prescaler, period and
// compare settings are shadowed and only take effect at a period wrap or at start-up.
module mbldcm_pwm_gen
  import mbldcm_pkg::*;
#(
  parameter int   pPrscWidth = cPrscWidth,
  parameter int   pCntWidth  = cCntWidth,
  parameter logic pIdleLevel = 1'b0
) (
  input  logic            iClock,
  input  logic            iReset_n,
  mbldcm_pwm_gen_if.slave pwmIf
);

  pwmState_t             rState;
  pwmState_t             wStateNxt;
  logic                  wLoad;
  logic                  wPrscClear;
  logic                  wTick;
  logic                  wWrap;
  logic                  wActive;
  logic [pPrscWidth-1:0] shPrsc;
  logic [pCntWidth-1:0]  shMaxCnt;
  logic [pCntWidth:0]    shCmp;
  logic [pCntWidth-1:0]  rCnt;
  logic                  rPwm;
  logic                  rPeriodEnd;

  // Compare is one bit wider than the counter so a compare above maxcnt means "always high".
  function automatic logic fDutyHigh(input logic [pCntWidth-1:0] cnt,
                                     input logic [pCntWidth:0]   cmp);
    return ({1'b0, cnt} < cmp);
  endfunction

  always_ff @(posedge iClock) begin
    if (!iReset_n) begin
      rState <= IDLE;
    end else begin
      rState <= wStateNxt;
    end
  end

  always_comb begin
    wStateNxt = rState;
    wLoad     = 1'b0;
    case (rState)
      IDLE: begin
        if (pwmIf.iEnable) begin
          wStateNxt = RUN;
          wLoad     = 1'b1;
        end
      end
      RUN: begin
        if (!pwmIf.iEnable) begin
          wStateNxt = IDLE;
        end
      end
      default: wStateNxt = IDLE;
    endcase
  end

  // Counting only happens in RUN with the enable still high; a falling enable wins over a wrap.
  assign wActive    = (rState == RUN) && pwmIf.iEnable;
  assign wPrscClear = !wActive;
  assign wWrap      = wTick && (rCnt == shMaxCnt);

  mbldcm_prescaler #(
    .pPrscWidth(pPrscWidth)
  ) uPrescaler (
    .iClock  (iClock),
    .iReset_n(iReset_n),
    .iClear  (wPrscClear),
    .iPrsc   (shPrsc),
    .oTick   (wTick)
  );

  always_ff @(posedge iClock) begin
    if (!iReset_n) begin
      shPrsc     <= pPrscWidth'(cPrscRst);
      shMaxCnt   <= pCntWidth'(cMaxCntRst);
      shCmp      <= (pCntWidth + 1)'(cCmpRst);
      rCnt       <= '0;
      rPwm       <= pIdleLevel;
      rPeriodEnd <= 1'b0;
    end else begin
      rPeriodEnd <= 1'b0;
      if (wLoad) begin
        shPrsc   <= pwmIf.iPwmPrsc;
        shMaxCnt <= pwmIf.iPwmMaxCnt;
        shCmp    <= pwmIf.iPwmCmp;
        rCnt     <= '0;
        rPwm     <= pIdleLevel;
      end else if (wActive) begin
        rPwm <= fDutyHigh(rCnt, shCmp);
        if (wWrap) begin
          rCnt       <= '0;
          rPeriodEnd <= 1'b1;
          shPrsc     <= pwmIf.iPwmPrsc;
          shMaxCnt   <= pwmIf.iPwmMaxCnt;
          shCmp      <= pwmIf.iPwmCmp;
        end else if (wTick) begin
          rCnt <= rCnt + 1'b1;
        end
      end else begin
        rCnt <= '0;
        rPwm <= pIdleLevel;
      end
    end
  end

  assign pwmIf.oPwm       = rPwm;
  assign pwmIf.oPeriodEnd = rPeriodEnd;
  assign pwmIf.oRunning   = (rState == RUN);

endmodule

// File: tb/tb_mbldcm_pwm_gen.sv
// Testbench for mbldcm_pwm_gen: table of waveform vectors, directed corner sequences
// and a randomized run against a phase-based reference model.
module tb_mbldcm_pwm_gen;
  import mbldcm_pkg::*;

  localparam int   PW       = 6;
  localparam int   CW       = 16;
  localparam logic IDLE_LVL = 1'b0;

  logic iClock   = 1'b0;
  logic iReset_n = 1'b0;

  mbldcm_pwm_gen_if #(.pPrscWidth(PW), .pCntWidth(CW)) pwmIf ();

  mbldcm_pwm_gen #(
    .pPrscWidth(PW),
    .pCntWidth (CW),
    .pIdleLevel(IDLE_LVL)
  ) dut (
    .iClock  (iClock),
    .iReset_n(iReset_n),
    .pwmIf   (pwmIf)
  );

  always #5 iClock = ~iClock;

  int nChecks = 0;
  int nFail   = 0;

  typedef struct {
    int prsc;
    int maxc;
    int cmp;
    int expPer;
    int expHigh;
  } vec_t;

  vec_t vecs[8];

  // Reference model state: run flag, clock phase inside the period, latched settings.
  bit   mRun;
  int   mPh, mPrsc, mMax, mCmp;
  logic ePwm, ePe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic stepClk();
    @(posedge iClock);
    @(negedge iClock);
  endtask

  task automatic setCfg(input int p, input int m, input int c);
    pwmIf.iPwmPrsc   = PW'(p);
    pwmIf.iPwmMaxCnt = CW'(m);
    pwmIf.iPwmCmp    = (CW + 1)'(c);
  endtask

  task automatic waitPe(input int budget, output int clks, output bit ok);
    clks = 0;
    ok   = 1'b0;
    while (clks < budget && !ok) begin
      stepClk();
      clks++;
      if (pwmIf.oPeriodEnd === 1'b1) ok = 1'b1;
    end
  endtask

  // Starting just after a period-end sample, count clocks and high samples up to the next one.
  task automatic measure(input int budget, output int per, output int high);
    bit done;
    per  = 0;
    high = 0;
    done = 1'b0;
    while (!done && per < budget) begin
      stepClk();
      per++;
      if (pwmIf.oPwm === 1'b1) high++;
      if (pwmIf.oPeriodEnd === 1'b1) done = 1'b1;
    end
  endtask

  task automatic modelLatch();
    mPrsc = int'(pwmIf.iPwmPrsc);
    mMax  = int'(pwmIf.iPwmMaxCnt);
    mCmp  = int'(pwmIf.iPwmCmp);
  endtask

  // Expected outputs after the coming clock edge, from the inputs currently applied.
  task automatic modelStep();
    if (!iReset_n) begin
      mRun = 1'b0; mPh = 0; mPrsc = 0; mMax = 65535; mCmp = 0;
      ePwm = IDLE_LVL; ePe = 1'b0;
    end else if (!mRun) begin
      ePwm = IDLE_LVL; ePe = 1'b0;
      if (pwmIf.iEnable) begin
        mRun = 1'b1; mPh = 0;
        modelLatch();
      end
    end else if (!pwmIf.iEnable) begin
      mRun = 1'b0; ePwm = IDLE_LVL; ePe = 1'b0;
    end else begin
      ePwm = ((mPh / (mPrsc + 1)) < mCmp) ? 1'b1 : 1'b0;
      if (mPh == (mPrsc + 1) * (mMax + 1) - 1) begin
        ePe = 1'b1; mPh = 0;
        modelLatch();
      end else begin
        ePe = 1'b0; mPh++;
      end
    end
  endtask

  initial begin
    int  clks, per, high, lows;
    bit  ok;

    vecs[0] = '{prsc: 0, maxc: 9,  cmp: 3,       expPer: 10, expHigh: 3};
    vecs[1] = '{prsc: 3, maxc: 4,  cmp: 2,       expPer: 20, expHigh: 8};
    vecs[2] = '{prsc: 0, maxc: 9,  cmp: 0,       expPer: 10, expHigh: 0};
    vecs[3] = '{prsc: 2, maxc: 0,  cmp: 1,       expPer: 3,  expHigh: 3};
    vecs[4] = '{prsc: 1, maxc: 5,  cmp: 'h10000, expPer: 12, expHigh: 12};
    vecs[5] = '{prsc: 0, maxc: 7,  cmp: 8,       expPer: 8,  expHigh: 8};
    vecs[6] = '{prsc: 0, maxc: 7,  cmp: 7,       expPer: 8,  expHigh: 7};
    vecs[7] = '{prsc: 2, maxc: 0,  cmp: 0,       expPer: 3,  expHigh: 0};

    pwmIf.iEnable = 1'b0;
    setCfg(5, 5, 5);
    iReset_n = 1'b0;
    @(negedge iClock);
    stepClk();
    chk("rst_pwm", pwmIf.oPwm, IDLE_LVL);
    chk("rst_pe", pwmIf.oPeriodEnd, 0);
    chk("rst_running", pwmIf.oRunning, 0);
    chk("rst_shmax", dut.shMaxCnt, 'hFFFF);
    iReset_n = 1'b1;
    stepClk();
    chk("idle_running", pwmIf.oRunning, 0);

    for (int i = 0; i < 8; i++) begin
      pwmIf.iEnable = 1'b0;
      stepClk();
      stepClk();
      setCfg(vecs[i].prsc, vecs[i].maxc, vecs[i].cmp);
      pwmIf.iEnable = 1'b1;
      waitPe(2 * vecs[i].expPer + 4, clks, ok);
      chk($sformatf("vec%0d_first_pe", i), ok, 1);
      chk($sformatf("vec%0d_first_lat", i), clks, vecs[i].expPer + 1);
      measure(2 * vecs[i].expPer + 4, per, high);
      chk($sformatf("vec%0d_period", i), per, vecs[i].expPer);
      chk($sformatf("vec%0d_high", i), high, vecs[i].expHigh);
      chk($sformatf("vec%0d_running", i), pwmIf.oRunning, 1);
    end

    // Compare change in mid-period only shows up after the next wrap.
    pwmIf.iEnable = 1'b0;
    stepClk();
    stepClk();
    setCfg(0, 9, 3);
    pwmIf.iEnable = 1'b1;
    waitPe(30, clks, ok);
    chk("mid_pe", ok, 1);
    pwmIf.iPwmCmp = 17'd7;
    measure(30, per, high);
    chk("mid_cur_high", high, 3);
    measure(30, per, high);
    chk("mid_next_high", high, 7);

    // Disable while high, then restart from zero.
    stepClk();
    chk("dis_high_before", pwmIf.oPwm, 1);
    pwmIf.iEnable = 1'b0;
    stepClk();
    chk("dis_pwm", pwmIf.oPwm, IDLE_LVL);
    chk("dis_running", pwmIf.oRunning, 0);
    stepClk();
    chk("dis_pe", pwmIf.oPeriodEnd, 0);
    pwmIf.iEnable = 1'b1;
    waitPe(30, clks, ok);
    chk("reen_lat", clks, 11);

    // Enable falls on the very clock the counter would wrap.
    for (int k = 0; k < 9; k++) stepClk();
    pwmIf.iEnable = 1'b0;
    stepClk();
    chk("wrapdis_pe", pwmIf.oPeriodEnd, 0);
    chk("wrapdis_running", pwmIf.oRunning, 0);

    // One-clock reset while running mid-high.
    setCfg(0, 9, 3);
    pwmIf.iEnable = 1'b1;
    waitPe(30, clks, ok);
    stepClk();
    iReset_n = 1'b0;
    stepClk();
    chk("midrst_pwm", pwmIf.oPwm, IDLE_LVL);
    chk("midrst_pe", pwmIf.oPeriodEnd, 0);
    chk("midrst_running", pwmIf.oRunning, 0);
    chk("midrst_shmax", dut.shMaxCnt, 'hFFFF);
    iReset_n = 1'b1;
    stepClk();
    chk("midrst_load_pwm", pwmIf.oPwm, IDLE_LVL);
    stepClk();
    chk("midrst_restart_pwm", pwmIf.oPwm, 1);

    // Compare above full-scale maxcnt: never low, including across the wrap.
    pwmIf.iEnable = 1'b0;
    stepClk();
    setCfg(0, 65535, 'h10000);
    pwmIf.iEnable = 1'b1;
    stepClk();
    lows = 0;
    clks = 0;
    ok   = 1'b0;
    while (!ok && clks < 65600) begin
      stepClk();
      clks++;
      if (pwmIf.oPwm !== 1'b1) lows++;
      if (pwmIf.oPeriodEnd === 1'b1) ok = 1'b1;
    end
    for (int k = 0; k < 4; k++) begin
      stepClk();
      if (pwmIf.oPwm !== 1'b1) lows++;
    end
    chk("full_pe", ok, 1);
    chk("full_period", clks, 65536);
    chk("full_lows", lows, 0);

    // Randomized run against the reference model.
    pwmIf.iEnable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      iReset_n = (i < 2) ? 1'b0 : ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 149) == 0) pwmIf.iEnable = ~pwmIf.iEnable;
      if ($urandom_range(0, 19) == 0) begin
        setCfg($urandom_range(0, 3), $urandom_range(0, 12),
               ($urandom_range(0, 7) == 0) ? 'h10000 : $urandom_range(0, 14));
      end
      modelStep();
      stepClk();
      chk("rnd_pwm", pwmIf.oPwm, ePwm);
      chk("rnd_pe", pwmIf.oPeriodEnd, ePe);
      chk("rnd_running", pwmIf.oRunning, mRun);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
